// File: rtl/mcu_stage_sequencer.sv
// Stage sequencer: loads program words into program memory, then cycles
// FETCH/DECODE/EXECUTE until a reload request is seen in EXECUTE.
module mcu_stage_sequencer #(
  parameter int PROG_DEPTH = 256,
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               reload_req,
  output logic               pm_we,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [INSTR_W-1:0] pm_wdata,
  output logic [1:0]         stage,
  output logic [ADDR_W:0]    prog_len,
  output logic               running
);

  localparam logic [1:0] STG_LOAD    = 2'b00;
  localparam logic [1:0] STG_FETCH   = 2'b01;
  localparam logic [1:0] STG_DECODE  = 2'b10;
  localparam logic [1:0] STG_EXECUTE = 2'b11;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(PROG_DEPTH);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    LOAD_ACCEPT,
    LOAD_DRAIN,
    FETCH,
    DECODE,
    EXECUTE
  } state_t;

  state_t           state;
  logic [ADDR_W:0]  cnt;
  logic [ADDR_W:0]  cnt_inc;
  logic             accept;

  // Ready depends only on registered state so the source never sees a loop.
  assign load_ready = (state == LOAD_ACCEPT) && (cnt < DEPTH);
  assign accept     = load_valid && load_ready;
  assign cnt_inc    = cnt + ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD_ACCEPT;
      cnt      <= '0;
      prog_len <= '0;
      pm_we    <= 1'b0;
      pm_addr  <= '0;
      pm_wdata <= '0;
      stage    <= STG_LOAD;
      running  <= 1'b0;
    end else begin
      pm_we <= accept;
      if (accept) begin
        pm_addr  <= cnt[ADDR_W-1:0];
        pm_wdata <= load_data;
      end

      case (state)
        LOAD_ACCEPT: begin
          if (accept) begin
            cnt <= cnt_inc;
            if (load_last || (cnt_inc == DEPTH)) state <= LOAD_DRAIN;
          end
        end
        // One extra cycle so the final write pulse lands while still in LOAD.
        LOAD_DRAIN: begin
          prog_len <= cnt;
          state    <= FETCH;
          stage    <= STG_FETCH;
          running  <= 1'b1;
        end
        FETCH: begin
          state <= DECODE;
          stage <= STG_DECODE;
        end
        DECODE: begin
          state <= EXECUTE;
          stage <= STG_EXECUTE;
        end
        EXECUTE: begin
          if (reload_req) begin
            state   <= LOAD_ACCEPT;
            cnt     <= '0;
            stage   <= STG_LOAD;
            running <= 1'b0;
          end else begin
            state <= FETCH;
            stage <= STG_FETCH;
          end
        end
        default: begin
          state   <= LOAD_ACCEPT;
          cnt     <= '0;
          stage   <= STG_LOAD;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_stage_sequencer.sv
// Bench for mcu_stage_sequencer: directed vector table, hand-written corner
// sequences and random stimulus, all checked against a behavioural model.
module tb_mcu_stage_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int IW    = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [IW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          reload_req;
  logic          pm_we;
  logic [AW-1:0] pm_addr;
  logic [IW-1:0] pm_wdata;
  logic [1:0]    stage;
  logic [AW:0]   prog_len;
  logic          running;

  mcu_stage_sequencer #(.PROG_DEPTH(DEPTH), .ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .reload_req(reload_req),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .stage(stage), .prog_len(prog_len), .running(running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int wq_addr[$];
  int wq_data[$];

  // Behavioural model: mode flags, word count and a run-phase index 0..2.
  bit m_loading, m_draining;
  int m_words, m_plen, m_phase;
  bit m_we;
  int m_addr, m_data;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int m_stage();
    return (m_loading || m_draining) ? 0 : m_phase + 1;
  endfunction

  function automatic bit m_ready();
    return m_loading && (m_words < DEPTH);
  endfunction

  task automatic model_reset();
    m_loading = 1; m_draining = 0; m_words = 0; m_plen = 0; m_phase = 0;
    m_we = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_update();
    bit acc;
    if (rst) begin
      model_reset();
    end else begin
      acc  = load_valid && m_ready();
      m_we = acc;
      if (acc) begin m_addr = m_words; m_data = int'(load_data); end
      if (m_draining) begin
        m_plen = m_words; m_draining = 0; m_phase = 0;
      end else if (m_loading) begin
        if (acc) begin
          m_words++;
          if (load_last || m_words == DEPTH) begin m_loading = 0; m_draining = 1; end
        end
      end else if (m_phase == 2 && reload_req) begin
        m_loading = 1; m_words = 0;
      end else begin
        m_phase = (m_phase + 1) % 3;
      end
    end
  endtask

  // Observe mid-cycle (negedge), compare against the model, log writes.
  task automatic tick();
    @(negedge clk);
    if (pm_we) begin wq_addr.push_back(int'(pm_addr)); wq_data.push_back(int'(pm_wdata)); end
    if (chk_en) begin
      chk("m_stage", int'(stage), m_stage());
      chk("m_ready", int'(load_ready), int'(m_ready()));
      chk("m_running", int'(running), int'(m_stage() != 0));
      chk("m_we", int'(pm_we), int'(m_we));
      if (m_we) begin
        chk("m_addr", int'(pm_addr), m_addr);
        chk("m_wdata", int'(pm_wdata), m_data);
      end
      chk("m_prog_len", int'(prog_len), m_plen);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    tick();
    adv();
  endtask

  task automatic drive(input bit v, input int d, input bit l, input bit rl);
    load_valid = v; load_data = IW'(d); load_last = l; reload_req = rl;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  typedef struct {
    bit v; int d; bit l; bit rl;
    int e_stage; bit e_ready; bit e_we; int e_addr; int e_data; int e_plen;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit v, input int d, input bit l, input bit rl,
                     input int es, input bit er, input bit ew, input int ea, input int ed, input int ep);
    vec_t t;
    t = '{v, d, l, rl, es, er, ew, ea, ed, ep};
    tbl.push_back(t);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    model_reset();

    // 3-word load, run loop x3, reload ignored in F/D then taken in E, 2-word reload.
    add(1, 'hA01, 0, 0,  0, 1, 0, 0, 0,       0);
    add(1, 'h2F0, 0, 0,  0, 1, 1, 0, 'hA01,   0);
    add(1, 'h8C3, 1, 0,  0, 1, 1, 1, 'h2F0,   0);
    add(1, 'h555, 0, 0,  0, 0, 1, 2, 'h8C3,   0);
    for (int r = 0; r < 3; r++) begin
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
      add(0, 0, 0, 0, 2, 0, 0, 0, 0, 3);
      add(0, 0, 0, 0, 3, 0, 0, 0, 0, 3);
    end
    add(0, 0, 0, 1,      1, 0, 0, 0, 0,       3);
    add(0, 0, 0, 1,      2, 0, 0, 0, 0,       3);
    add(0, 0, 0, 1,      3, 0, 0, 0, 0,       3);
    add(1, 'h111, 0, 0,  0, 1, 0, 0, 0,       3);
    add(1, 'h222, 1, 0,  0, 1, 1, 0, 'h111,   3);
    add(0, 0, 0, 0,      0, 0, 1, 1, 'h222,   3);
    add(0, 0, 0, 0,      1, 0, 0, 0, 0,       2);

    do_reset();
    tick();
    chk("rst_stage", int'(stage), 0);
    chk("rst_we", int'(pm_we), 0);
    chk("rst_addr", int'(pm_addr), 0);
    chk("rst_wdata", int'(pm_wdata), 0);
    chk("rst_plen", int'(prog_len), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_ready", int'(load_ready), 1);
    adv();

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rl);
      tick();
      chk($sformatf("tbl%0d_stage", i), int'(stage), tbl[i].e_stage);
      chk($sformatf("tbl%0d_ready", i), int'(load_ready), int'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_we", i), int'(pm_we), int'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("tbl%0d_addr", i), int'(pm_addr), tbl[i].e_addr);
        chk($sformatf("tbl%0d_data", i), int'(pm_wdata), tbl[i].e_data);
      end
      chk($sformatf("tbl%0d_plen", i), int'(prog_len), tbl[i].e_plen);
      adv();
    end

    // Overflow: 6 words without last, only DEPTH accepted.
    do_reset();
    wq_addr.delete(); wq_data.delete();
    for (int i = 0; i < 6; i++) begin
      drive(1, 'h300 + i, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0);
    tick();
    chk("ovf_writes", wq_addr.size(), DEPTH);
    foreach (wq_addr[i]) chk("ovf_addr", wq_addr[i], i);
    chk("ovf_running", int'(running), 1);
    chk("ovf_plen", int'(prog_len), DEPTH);
    adv();

    // Gapped valid with load_last only on idle cycles: 3 accepts, still loading.
    do_reset();
    wq_addr.delete(); wq_data.delete();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(1, 'h400 + i, 0, 0);
      else            drive(0, 'h7FF, 1, 0);
      cycle();
    end
    drive(0, 0, 0, 0);
    tick();
    chk("gap_writes", wq_addr.size(), 3);
    foreach (wq_addr[i]) begin
      chk("gap_addr", wq_addr[i], i);
      chk("gap_data", wq_data[i], 'h400 + 2 * i);
    end
    chk("gap_stage", int'(stage), 0);
    chk("gap_ready", int'(load_ready), 1);
    adv();

    // Reset mid-load, colliding with an accept; next word must land at addr 0.
    do_reset();
    drive(1, 'h501, 0, 0); cycle();
    drive(1, 'h502, 0, 0); cycle();
    drive(1, 'h503, 0, 0); rst = 1'b1; cycle();
    rst = 1'b0; drive(0, 0, 0, 0);
    tick();
    chk("rml_we", int'(pm_we), 0);
    chk("rml_stage", int'(stage), 0);
    adv();
    wq_addr.delete(); wq_data.delete();
    drive(1, 'h504, 0, 0); cycle();
    drive(0, 0, 0, 0); cycle();
    chk("rml_writes", wq_addr.size(), 1);
    if (wq_addr.size() > 0) begin
      chk("rml_addr0", wq_addr[0], 0);
      chk("rml_data0", wq_data[0], 'h504);
    end

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
